// File: rtl/gemm_mac_seq_if.sv
// rtl/gemm_mac_seq_if.sv - result stream interface between gemm_mac_seq and the result writer
interface gemm_mac_seq_if #(
    parameter int DIM_W = 4,
    parameter int ACC_W = 19
);
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [DIM_W-1:0] res_row;
    logic [DIM_W-1:0] res_col;
    logic             res_last;

    modport master (
        output res_valid, res_data, res_row, res_col, res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_row, res_col, res_last,
        output res_ready
    );
endinterface

// File: rtl/gemm_mac_seq.sv
// rtl/gemm_mac_seq.sv - sequences one accumulating mac unit to compute C = A x B element by element
module gemm_mac_seq #(
    parameter int DIM_W  = 4,
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic [DIM_W-1:0]  cfg_k,
    output logic              busy,
    output logic              done,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_rd_data,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_rd_data,
    output logic              macc_clear,
    output logic [7:0]        inA,
    output logic [7:0]        inB,
    input  logic [ACC_W-1:0]  macc_out,
    gemm_mac_seq_if.master    res
);

    typedef enum logic [2:0] {IDLE, CLEAR, ACC, OUT, FIN} state_t;

    state_t            state;
    logic [DIM_W-1:0]  m_q, n_q, k_q;
    logic [DIM_W-1:0]  i_q, j_q, k_cnt;
    logic              valid_q, last_q;
    logic [DIM_W-1:0]  row_q, col_q;
    logic              j_wrap;
    logic [DIM_W-1:0]  i_nxt, j_nxt;
    logic [ADDR_W-1:0] n_ext, k_ext;

    assign n_ext = ADDR_W'(n_q);
    assign k_ext = ADDR_W'(k_q);

    always_comb begin
        j_wrap = (j_q == n_q - DIM_W'(1));
        i_nxt  = j_wrap ? i_q + DIM_W'(1) : i_q;
        j_nxt  = j_wrap ? '0 : j_q + DIM_W'(1);
    end

    // Operands arrive one cycle after the read strobe, so they feed the mac straight through.
    assign inA = (state == ACC) ? a_rd_data : '0;
    assign inB = (state == ACC) ? b_rd_data : '0;

    assign res.res_valid = valid_q;
    assign res.res_data  = valid_q ? macc_out : '0;
    assign res.res_row   = row_q;
    assign res.res_col   = col_q;
    assign res.res_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_rd_en    <= 1'b0;
            a_addr     <= '0;
            b_rd_en    <= 1'b0;
            b_addr     <= '0;
            macc_clear <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_m != '0 && cfg_n != '0 && cfg_k != '0) begin
                            m_q        <= cfg_m;
                            n_q        <= cfg_n;
                            k_q        <= cfg_k;
                            i_q        <= '0;
                            j_q        <= '0;
                            busy       <= 1'b1;
                            macc_clear <= 1'b1;
                            a_rd_en    <= 1'b1;
                            b_rd_en    <= 1'b1;
                            a_addr     <= '0;
                            b_addr     <= '0;
                            state      <= CLEAR;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                CLEAR: begin
                    macc_clear <= 1'b0;
                    k_cnt      <= '0;
                    state      <= ACC;
                    if (k_q != DIM_W'(1)) begin
                        a_addr <= a_addr + ADDR_W'(1);
                        b_addr <= b_addr + n_ext;
                    end else begin
                        a_rd_en <= 1'b0;
                        b_rd_en <= 1'b0;
                        a_addr  <= '0;
                        b_addr  <= '0;
                    end
                end
                ACC: begin
                    if (k_cnt == k_q - DIM_W'(1)) begin
                        valid_q <= 1'b1;
                        row_q   <= i_q;
                        col_q   <= j_q;
                        last_q  <= (i_q == m_q - DIM_W'(1)) && j_wrap;
                        state   <= OUT;
                    end else begin
                        k_cnt <= k_cnt + DIM_W'(1);
                        // The read issued now is for operand k_cnt+2; none exists past K-1.
                        if (k_cnt == k_q - DIM_W'(2)) begin
                            a_rd_en <= 1'b0;
                            b_rd_en <= 1'b0;
                            a_addr  <= '0;
                            b_addr  <= '0;
                        end else begin
                            a_addr <= a_addr + ADDR_W'(1);
                            b_addr <= b_addr + n_ext;
                        end
                    end
                end
                OUT: begin
                    if (res.res_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                        if (last_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            i_q        <= i_nxt;
                            j_q        <= j_nxt;
                            macc_clear <= 1'b1;
                            a_rd_en    <= 1'b1;
                            b_rd_en    <= 1'b1;
                            a_addr     <= ADDR_W'(i_nxt) * k_ext;
                            b_addr     <= ADDR_W'(j_nxt);
                            state      <= CLEAR;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_mac_seq.sv
// tb/tb_gemm_mac_seq.sv - self-checking bench for gemm_mac_seq with buffer and mac models
module tb_gemm_mac_seq;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
    logic          busy, done, a_rd_en, b_rd_en, macc_clear;
    logic [7:0]    a_addr, b_addr, inA, inB;
    logic [7:0]    a_rd_data = '0, b_rd_data = '0;
    logic [18:0]   acc;
    logic [7:0]    a_mem [256];
    logic [7:0]    b_mem [256];
    logic          mon_en = 1'b0;
    int            checks = 0, errors = 0;

    gemm_mac_seq_if #(.DIM_W(DW), .ACC_W(19)) res_if ();

    gemm_mac_seq #(.DIM_W(DW), .ADDR_W(8), .ACC_W(19)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rd_data(b_rd_data),
        .macc_clear(macc_clear), .inA(inA), .inB(inB), .macc_out(acc),
        .res(res_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          acc <= '0;
        else if (macc_clear) acc <= '0;
        else                 acc <= acc + 19'(int'($signed(inA)) * int'($signed(inB)));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en)
            check("bus_quiet",
                  {(!a_rd_en && a_addr != 0) || (!b_rd_en && b_addr != 0),
                   res_if.res_valid && (a_rd_en || b_rd_en || macc_clear || inA != 0 || inB != 0)},
                  64'd0);
    end

    task automatic load_rand(input int m, input int n, input int k);
        for (int x = 0; x < m * k; x++) a_mem[x] = 8'($urandom);
        for (int x = 0; x < k * n; x++) b_mem[x] = 8'($urandom);
    endtask

    task automatic run_job(input int m, input int n, input int k, input int stall,
                           input bit intrude, input bit use_lit, input logic [18:0] lit);
        logic [18:0] exp_q[$];
        int          er[$], ec[$];
        int          s, cyc;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++)
                    s += int'($signed(a_mem[i*k+kk])) * int'($signed(b_mem[kk*n+j]));
                exp_q.push_back(19'(s));
                er.push_back(i);
                ec.push_back(j);
            end
        res_if.res_ready = (stall == 0);
        cfg_m = DW'(m); cfg_n = DW'(n); cfg_k = DW'(k);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (m * n * k == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_valid", res_if.res_valid, 0);
            @(posedge clk); #1;
            check("zero_done_end", done, 0);
            check("zero_busy_end", busy, 0);
            return;
        end
        check("busy_start", busy, 1);
        cyc = 1;
        if (intrude) begin
            @(posedge clk); #1;
            cfg_m = DW'($urandom_range(1, 15)); cfg_n = DW'($urandom_range(1, 15));
            cfg_k = DW'($urandom_range(1, 15)); start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        cyc = 0;
        for (int e = 0; e < exp_q.size(); e++) begin
            do begin @(negedge clk); cyc++; end while (!res_if.res_valid && cyc < 200);
            check("valid", res_if.res_valid, 1);
            if (!(intrude && e == 0)) check("latency", cyc, k + 2);
            check("data", res_if.res_data, exp_q[e]);
            check("row", res_if.res_row, er[e]);
            check("col", res_if.res_col, ec[e]);
            check("last", res_if.res_last, (e == exp_q.size() - 1));
            if (use_lit && e == 0) check("literal", res_if.res_data, lit);
            for (int h = 0; h < stall; h++) begin
                @(negedge clk);
                check("hold_valid", res_if.res_valid, 1);
                check("hold_data", res_if.res_data, exp_q[e]);
                check("hold_pos", {res_if.res_row, res_if.res_col}, {DW'(er[e]), DW'(ec[e])});
            end
            res_if.res_ready = 1'b1;
            @(posedge clk); #1;
            res_if.res_ready = (stall == 0);
            cyc = 0;
        end
        @(negedge clk);
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("valid_end", res_if.res_valid, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {busy, done, a_rd_en, b_rd_en, macc_clear,
                               res_if.res_valid, res_if.res_last}, 64'd0);
        check({tag, "_bus"}, {a_addr, b_addr, inA, inB, res_if.res_row, res_if.res_col}, 64'd0);
        check({tag, "_data"}, res_if.res_data, 64'd0);
    endtask

    task automatic load_t1();
        for (int x = 0; x < 6; x++) a_mem[x] = 8'(x + 1);
        for (int x = 0; x < 6; x++) b_mem[x] = 8'(x + 7);
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;

        load_t1();
        run_job(2, 2, 3, 0, 1'b0, 1'b1, 19'd58);
        run_job(2, 2, 3, 3, 1'b0, 1'b1, 19'd58);

        a_mem[0] = 8'hFC; a_mem[1] = 8'h07; b_mem[0] = 8'h01; b_mem[1] = 8'hFA;
        run_job(1, 1, 2, 0, 1'b0, 1'b1, 19'h7FFD2);

        run_job(2, 3, 0, 0, 1'b0, 1'b0, 19'd0);
        run_job(0, 3, 2, 0, 1'b0, 1'b0, 19'd0);

        for (int x = 0; x < 16; x++) begin a_mem[x] = 8'h80; b_mem[x] = 8'h80; end
        run_job(1, 1, 16, 0, 1'b0, 1'b1, 19'h40000);

        // Reset lands in the ACC phase of element (0,1) of a 2x2x4 job.
        load_rand(2, 2, 4);
        res_if.res_ready = 1'b1;
        cfg_m = DW'(2); cfg_n = DW'(2); cfg_k = DW'(4);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("mid_acc_rd", a_rd_en, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1 check_all_zero("held_rst");
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_rst_valid", res_if.res_valid, 0);
        run_job(2, 2, 4, 0, 1'b0, 1'b0, 19'd0);

        load_t1();
        run_job(2, 2, 3, 0, 1'b1, 1'b1, 19'd58);

        for (int r = 0; r < 6; r++) begin
            int m, n, k;
            m = $urandom_range(1, 4); n = $urandom_range(1, 4); k = $urandom_range(1, 8);
            load_rand(m, n, k);
            run_job(m, n, k, $urandom_range(0, 2), 1'b0, 1'b0, 19'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
